// File: rtl/pcie_dma_pkg.sv
// pcie_dma_pkg: shared types and constants for the PCIe DMA read sequencer
package pcie_dma_pkg;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 128;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} rd_seq_state_e;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
    logic              last;
  } rd_entry_t;
endpackage

// File: rtl/rd_seq_fifo.sv
// rd_seq_fifo: first-word-fall-through FIFO of read entries with occupancy count
module rd_seq_fifo
  import pcie_dma_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  rd_entry_t din,
  input  logic      pop,
  output rd_entry_t dout,
  output logic [AW:0] count
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  rd_entry_t mem_q [DEPTH];
  rd_entry_t mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  // pointer/count update; push on full and pop on empty are dropped
  always_comb begin
    do_push = push && cnt_q != FULL;
    do_pop = pop && cnt_q != '0;
    wr_d = wr_q + AW'(do_push);
    rd_d = rd_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = din;
  end
  // control state registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  // storage needs no reset; readers qualify it with count
  always_ff @(posedge clk) mem_q <= mem_d;
  assign dout = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/pcie_rd_seq.sv
// pcie_rd_seq: single-outstanding read sequencer feeding a FWFT output stream (RD_SEQ_PERF_CNT_EN adds PerfCycles)
module pcie_rd_seq
  import pcie_dma_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_STEP = 16,
  parameter int LEN_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              JobValid,
  output logic              JobReady,
  input  logic [ADDR_W-1:0] JobAddr,
  input  logic [LEN_W-1:0]  JobLen,
  output logic              JobDone,
  output logic              JobErr,
  output logic [ADDR_W-1:0] JobErrAddr,
  output logic              RqValid,
  output logic [ADDR_W-1:0] RqAddr,
  input  logic [DATA_W-1:0] RqData,
  input  logic              RqReady,
  input  logic              RqErr,
  output logic              OutValid,
  output logic [DATA_W-1:0] OutData,
  output logic              OutLast,
  output logic              OutErr,
  input  logic              OutReady,
  output logic              Busy
`ifdef RD_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]       PerfCycles
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  rd_seq_state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, err_addr_q, err_addr_d;
  logic [LEN_W-1:0] len_q, len_d, idx_q, idx_d;
  logic err_q, err_d, push, accept, rq_last;
  rd_entry_t din, dout;
  logic [CW-1:0] count;
  // sequencing: RqAddr advances by ADDR_STEP per completed word, wrapping silently
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    len_d = len_q;
    idx_d = idx_q;
    err_d = err_q;
    err_addr_d = err_addr_q;
    push = 1'b0;
    accept = 1'b0;
    rq_last = idx_q == len_q - LEN_W'(1) || RqErr;
    case (state_q)
      IDLE: if (JobValid) begin
        accept = 1'b1;
        addr_d = JobAddr;
        len_d = JobLen;
        idx_d = '0;
        err_d = 1'b0;
        err_addr_d = '0;
        state_d = JobLen == '0 ? FINISH : ISSUE;
      end
      ISSUE: if (count < FULL) state_d = WAIT;
      WAIT: if (RqReady) begin
        push = 1'b1;
        if (RqErr) begin
          err_d = 1'b1;
          err_addr_d = addr_q;
          state_d = FINISH;
        end else if (rq_last) state_d = FINISH;
        else begin
          idx_d = idx_q + LEN_W'(1);
          addr_d = addr_q + ADDR_W'(ADDR_STEP);
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // sequencer state registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      len_q <= '0;
      idx_q <= '0;
      err_q <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      len_q <= len_d;
      idx_q <= idx_d;
      err_q <= err_d;
      err_addr_q <= err_addr_d;
    end
  assign din = '{data: RqData, err: RqErr, last: rq_last};
  rd_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .din(din),
    .pop(OutReady),
    .dout(dout),
    .count(count)
  );
  assign JobReady = state_q == IDLE;
  assign Busy = state_q != IDLE;
  assign JobDone = state_q == FINISH;
  assign RqValid = state_q == ISSUE && count < FULL;
  assign RqAddr = addr_q;
  assign JobErr = err_q;
  assign JobErrAddr = err_addr_q;
  assign OutValid = count != '0;
  assign OutData = OutValid ? dout.data : '0;
  assign OutLast = OutValid & dout.last;
  assign OutErr = OutValid & dout.err;
`ifdef RD_SEQ_PERF_CNT_EN
  logic [31:0] run_q, run_d, perf_q, perf_d;
  // busy-cycle counter, published when the job finishes
  always_comb begin
    run_d = accept ? '0 : (Busy && ~&run_q) ? run_q + 32'd1 : run_q;
    perf_d = state_q == FINISH ? run_d : perf_q;
  end
  // performance counter registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      run_q <= '0;
      perf_q <= '0;
    end else begin
      run_q <= run_d;
      perf_q <= perf_d;
    end
  assign PerfCycles = perf_q;
`endif
endmodule

// File: tb/tb_pcie_rd_seq.sv
// tb_pcie_rd_seq: directed self-checking bench for pcie_rd_seq
module tb_pcie_rd_seq;
  logic clk = 0, rst_n;
  logic JobValid, JobReady, JobDone, JobErr, RqValid, RqReady, RqErr;
  logic OutValid, OutLast, OutErr, OutReady, Busy;
  logic [63:0] JobAddr, JobErrAddr, RqAddr;
  logic [15:0] JobLen;
  logic [127:0] RqData, OutData;
`ifdef RD_SEQ_PERF_CNT_EN
  logic [31:0] PerfCycles;
`endif
  int total = 0, bad = 0;
  int rq_cnt = 0, b2b = 0, done_cnt = 0, ov_cnt = 0, lat = 1, epoch = 0;
  int stray_n = 0, stray_done = 0;
  logic prev_rqv = 0, err_en = 0;
  logic [63:0] err_at = '0;
  logic [63:0] rq_addrs[$];
  logic [127:0] out_d[$], ctl_data[$];
  logic out_e[$], out_l[$];

  pcie_rd_seq dut (
    .clk(clk), .rst_n(rst_n), .JobValid(JobValid), .JobReady(JobReady),
    .JobAddr(JobAddr), .JobLen(JobLen), .JobDone(JobDone), .JobErr(JobErr),
    .JobErrAddr(JobErrAddr), .RqValid(RqValid), .RqAddr(RqAddr), .RqData(RqData),
    .RqReady(RqReady), .RqErr(RqErr), .OutValid(OutValid), .OutData(OutData),
    .OutLast(OutLast), .OutErr(OutErr), .OutReady(OutReady), .Busy(Busy)
`ifdef RD_SEQ_PERF_CNT_EN
    , .PerfCycles(PerfCycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] data_of(input logic [63:0] a);
    return {~a, a};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (RqValid) begin
      rq_cnt++;
      rq_addrs.push_back(RqAddr);
    end
    if (RqValid && prev_rqv) b2b++;
    prev_rqv = RqValid;
    if (JobDone) done_cnt++;
    if (OutValid) ov_cnt++;
    if (OutValid && OutReady) begin
      out_d.push_back(OutData);
      out_e.push_back(OutErr);
      out_l.push_back(OutLast);
    end
  end

  initial begin
    logic [63:0] a;
    int ep;
    RqReady = 0;
    RqErr = 0;
    RqData = '0;
    forever begin
      @(negedge clk);
      if (stray_n != stray_done) begin
        stray_done++;
        @(posedge clk); #1 RqReady = 1; RqErr = 1;
        @(posedge clk); #1 RqReady = 0; RqErr = 0;
      end else if (RqValid) begin
        a = RqAddr;
        ep = epoch;
        for (int i = 0; i < lat; i++) begin
          @(posedge clk);
          if (ep != epoch) break;
        end
        if (ep == epoch) begin
          #1 RqReady = 1;
          RqErr = err_en && a == err_at;
          RqData = ctl_data.size() != 0 ? ctl_data.pop_front() : data_of(a);
          @(posedge clk); #1 RqReady = 0; RqErr = 0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [63:0] addr, input logic [15:0] len);
    int i;
    for (i = 0; i < 200 && !JobReady; i++) tick(1);
    chk("job_ready_to", JobReady, 1);
    JobValid = 1;
    JobAddr = addr;
    JobLen = len;
    tick(1);
    JobValid = 0;
  endtask

  task automatic wait_done(input int d0, input string tag);
    for (int i = 0; i < 300 && done_cnt == d0; i++) tick(1);
    chk({tag, "_done_to"}, done_cnt != d0, 1);
  endtask

  initial begin
    int r0, o0, d0, c0;
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, o0, d0, c0, v0;
    logic [63:0] b;
    rst_n = 0;
    JobValid = 0;
    JobAddr = '0;
    JobLen = '0;
    OutReady = 1;
    tick(3);
    chk("rst_jobready", JobReady, 1);
    chk("rst_busy", Busy, 0);
    chk("rst_rqvalid", RqValid, 0);
    chk("rst_outvalid", OutValid, 0);
    chk("rst_jobdone", JobDone, 0);
    chk("rst_joberr", JobErr, 0);
    chk("rst_rqaddr", RqAddr, 0);
    rst_n = 1;
    tick(2);

    // basic three-word job
    r0 = rq_addrs.size(); o0 = out_d.size(); d0 = done_cnt;
    ctl_data.push_back(128'hA); ctl_data.push_back(128'hB); ctl_data.push_back(128'hC);
    start_job(64'h1000, 3);
    chk("t1_lat_rqvalid", RqValid, 1);
    chk("t1_busy", Busy, 1);
    wait_done(d0, "t1");
    tick(4);
    chk("t1_rq_n", rq_addrs.size() - r0, 3);
    for (int i = 0; i < 3; i++) chk($sformatf("t1_addr%0d", i), rq_addrs[r0+i], 64'h1000 + 64'(i * 16));
    chk("t1_out_n", out_d.size() - o0, 3);
    chk("t1_d0", out_d[o0], 128'hA);
    chk("t1_d1", out_d[o0+1], 128'hB);
    chk("t1_d2", out_d[o0+2], 128'hC);
    chk("t1_lasts", {out_l[o0], out_l[o0+1], out_l[o0+2]}, 3'b001);
    chk("t1_errs", {out_e[o0], out_e[o0+1], out_e[o0+2]}, 3'b000);
    chk("t1_done_n", done_cnt - d0, 1);
    chk("t1_joberr", JobErr, 0);

    // zero-length job, then stray RqReady/RqErr while idle
    r0 = rq_cnt; v0 = ov_cnt; d0 = done_cnt;
    start_job(64'h5000, 0);
    chk("t2_done_t1", JobDone, 1);
    tick(3);
    chk("t2_done_n", done_cnt - d0, 1);
    stray_n++;
    tick(5);
    chk("t2_rq_n", rq_cnt - r0, 0);
    chk("t2_ov_n", ov_cnt - v0, 0);
    chk("t2_busy", Busy, 0);
    chk("t2_joberr", JobErr, 0);

    // error on third word of four
    r0 = rq_addrs.size(); o0 = out_d.size(); d0 = done_cnt;
    err_en = 1; err_at = 64'h2020;
    start_job(64'h2000, 4);
    wait_done(d0, "t3");
    tick(6);
    err_en = 0;
    chk("t3_rq_n", rq_addrs.size() - r0, 3);
    chk("t3_out_n", out_d.size() - o0, 3);
    chk("t3_d2", out_d[o0+2], data_of(64'h2020));
    chk("t3_lasts", {out_l[o0], out_l[o0+1], out_l[o0+2]}, 3'b001);
    chk("t3_errs", {out_e[o0], out_e[o0+1], out_e[o0+2]}, 3'b001);
    chk("t3_joberr", JobErr, 1);
    chk("t3_erraddr", JobErrAddr, 64'h2020);

    // backpressure: FIFO fills after four requests
    OutReady = 0;
    r0 = rq_addrs.size(); o0 = out_d.size(); d0 = done_cnt;
    start_job(64'h4000, 8);
    chk("t4_joberr_clr", JobErr, 0);
    tick(40);
    chk("t4_stall_rq_n", rq_addrs.size() - r0, 4);
    chk("t4_stall_busy", Busy, 1);
    chk("t4_stall_ov", OutValid, 1);
    OutReady = 1;
    wait_done(d0, "t4");
    tick(8);
    chk("t4_rq_n", rq_addrs.size() - r0, 8);
    chk("t4_out_n", out_d.size() - o0, 8);
    for (int i = 0; i < 8; i++) begin
      b = 64'h4000 + 64'(i * 16);
      chk($sformatf("t4_addr%0d", i), rq_addrs[r0+i], b);
      chk($sformatf("t4_d%0d", i), out_d[o0+i], data_of(b));
      chk($sformatf("t4_last%0d", i), out_l[o0+i], i == 7);
    end

    // address wrap
    r0 = rq_addrs.size(); d0 = done_cnt;
    start_job(64'hFFFF_FFFF_FFFF_FFF0, 2);
    wait_done(d0, "t5");
    tick(4);
    chk("t5_rq_n", rq_addrs.size() - r0, 2);
    chk("t5_addr0", rq_addrs[r0], 64'hFFFF_FFFF_FFFF_FFF0);
    chk("t5_addr1", rq_addrs[r0+1], 64'h0);

    // reset while waiting for data
    lat = 20;
    start_job(64'h8000, 2);
    tick(3);
    chk("t6_busy_pre", Busy, 1);
    rst_n = 0;
    epoch++;
    #1;
    chk("t6_jobready", JobReady, 1);
    chk("t6_busy", Busy, 0);
    chk("t6_rqvalid", RqValid, 0);
    chk("t6_outvalid", OutValid, 0);
    chk("t6_jobdone", JobDone, 0);
    chk("t6_rqaddr", RqAddr, 0);
    chk("t6_erraddr", JobErrAddr, 0);
    tick(2);
    rst_n = 1;
    tick(2);
    lat = 5;
    r0 = rq_addrs.size(); o0 = out_d.size(); d0 = done_cnt;
    start_job(64'h9000, 1);
    wait_done(d0, "t7");
    tick(3);
    chk("t7_rq_n", rq_addrs.size() - r0, 1);
    chk("t7_addr", rq_addrs[r0], 64'h9000);
    chk("t7_out_n", out_d.size() - o0, 1);
    chk("t7_d0", out_d[o0], data_of(64'h9000));
    chk("t7_last", out_l[o0], 1);
`ifdef RD_SEQ_PERF_CNT_EN
    chk("t7_perf", PerfCycles, 7);
`endif
    chk("b2b_rqvalid", b2b, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
